// File: rtl/sha1_block_stream_padder.sv
// SHA-1 message fetch and padding front-end: reads the message from a dpsram port and
// streams padded 512-bit blocks as big-endian 32-bit words over valid/ready.
module sha1_block_stream_padder #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MEM_LE     = 0
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start_hash,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [31:0]       message_size,
  output logic              port_A_clk,
  output logic [15:0]       port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out,
  output logic [31:0]       word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [3:0]        word_idx,
  output logic              word_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned PIPE_N = RD_LAT + 1;
  localparam int unsigned PF_W   = $clog2(PIPE_N + 1);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } word_t;

  // keep: bytes retained from a partial SRAM word (0 = whole word)
  typedef struct packed {
    logic       vld;
    logic       is_mem;
    logic [1:0] keep;
    word_t      w;
  } tag_t;

  typedef enum logic [1:0] {IDLE, GEN, DRAIN, DONE} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         size_q, idx_q, total_q, total_n;
  logic [15:0]         port_addr_q;
  tag_t                pipe [PIPE_N];
  tag_t                new_tag, tail;
  word_t               fifo [FIFO_DEPTH];
  word_t               head, push_word;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    cnt_q;
  logic [PF_W-1:0]     in_flight;
  logic [31:0]         full_w, mem_words, gen_data, mem_word;
  logic [1:0]          rem;
  logic                is_mem, issue, bypass, push, pop;

  assign port_A_clk     = clk;
  assign port_A_addr    = port_addr_q;
  assign port_A_we      = 1'b0;
  assign port_A_data_in = 32'h0;

  assign head       = fifo[rd_ptr];
  assign word_valid = (cnt_q != '0);
  assign word_data  = head.data;
  assign word_idx   = head.idx;
  assign word_last  = head.last;
  assign pop        = word_valid && word_ready;

  assign total_n   = ((((32'({3'b0, message_size[28:0]}) + 32'd8) >> 6) + 32'd1) << 4);
  assign rem       = size_q[1:0];
  assign full_w    = 32'(size_q[28:2]);
  assign mem_words = full_w + 32'(rem != 2'd0);
  assign is_mem    = (idx_q < mem_words);

  always_comb begin
    in_flight = '0;
    for (int unsigned k = 0; k < PIPE_N; k++) in_flight = in_flight + PF_W'(pipe[k].vld);
  end

  // Credit check covers both FIFO occupancy and reads still in the SRAM pipe
  assign issue  = (state == GEN) && ((32'(cnt_q) + 32'(in_flight)) < 32'(FIFO_DEPTH));
  assign bypass = issue && !is_mem && (in_flight == '0);

  always_comb begin
    gen_data = 32'h0;
    if (idx_q == full_w)                 gen_data = 32'h8000_0000;
    else if (idx_q == total_q - 32'd2)   gen_data = {29'b0, size_q[31:29]};
    else if (idx_q == total_q - 32'd1)   gen_data = {size_q[28:0], 3'b0};
  end

  always_comb begin
    new_tag        = '0;
    new_tag.vld    = issue && !bypass;
    new_tag.is_mem = is_mem;
    new_tag.keep   = (idx_q == full_w) ? rem : 2'd0;
    new_tag.w.data = gen_data;
    new_tag.w.idx  = idx_q[3:0];
    new_tag.w.last = (idx_q == total_q - 32'd1);
  end

  assign tail = pipe[RD_LAT];

  always_comb begin
    mem_word = (MEM_LE != 0) ? {port_A_data_out[7:0], port_A_data_out[15:8],
                                port_A_data_out[23:16], port_A_data_out[31:24]}
                             : port_A_data_out;
    case (tail.keep)
      2'd1:    mem_word = {mem_word[31:24], 8'h80, 16'h0};
      2'd2:    mem_word = {mem_word[31:16], 8'h80, 8'h0};
      2'd3:    mem_word = {mem_word[31:8], 8'h80};
      default: mem_word = mem_word;
    endcase
    push_word = tail.w;
    if (tail.is_mem) push_word.data = mem_word;
    if (bypass) push_word = new_tag.w;
    push = tail.vld || bypass;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_hash) state_n = GEN;
      GEN:     if (issue && (idx_q == total_q - 32'd1)) state_n = DRAIN;
      DRAIN:   if (pop && head.last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      addr_q      <= '0;
      size_q      <= '0;
      idx_q       <= '0;
      total_q     <= '0;
      port_addr_q <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int unsigned k = 0; k < PIPE_N; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= new_tag;
      for (int unsigned k = 1; k < PIPE_N; k++) pipe[k] <= pipe[k-1];
      if (state == IDLE && start_hash) begin
        addr_q  <= message_addr;
        size_q  <= message_size;
        idx_q   <= '0;
        total_q <= total_n;
      end
      if (issue) begin
        idx_q <= idx_q + 32'd1;
        if (is_mem) begin
          port_addr_q <= 16'(addr_q);
          addr_q      <= addr_q + ADDR_W'(1);
        end
      end
      busy <= (state_n == GEN) || (state_n == DRAIN);
      done <= (state_n == DONE);
    end
  end

  // Output FIFO; credits guarantee no push ever lands on a full FIFO
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) fifo[k] <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= push_word;
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_sha1_block_stream_padder.sv
// Scoreboard bench for sha1_block_stream_padder: two instances (big-endian RD_LAT=1,
// little-endian RD_LAT=2) share one SRAM image; a byte-level padding model fills the queues.
module tb_sha1_block_stream_padder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset;
  logic [31:0] mem [0:255];

  logic        start0, start1;
  logic [15:0] maddr0, maddr1;
  logic [31:0] msize0, msize1;
  logic        pclk0, pclk1, pwe0, pwe1;
  logic [15:0] paddr0, paddr1;
  logic [31:0] pdin0, pdin1, pdout0, pdout1, s1, wd0, wd1;
  logic        wv0, wv1, wr0, wr1, wl0, wl1, busy0, busy1, done0, done1;
  logic [3:0]  wi0, wi1;

  sha1_block_stream_padder #(.ADDR_W(16), .FIFO_DEPTH(4), .RD_LAT(1), .MEM_LE(0)) dut0 (
    .clk(clk), .nreset(nreset), .start_hash(start0), .message_addr(maddr0),
    .message_size(msize0), .port_A_clk(pclk0), .port_A_addr(paddr0), .port_A_we(pwe0),
    .port_A_data_in(pdin0), .port_A_data_out(pdout0), .word_data(wd0), .word_valid(wv0),
    .word_ready(wr0), .word_idx(wi0), .word_last(wl0), .busy(busy0), .done(done0));

  sha1_block_stream_padder #(.ADDR_W(16), .FIFO_DEPTH(4), .RD_LAT(2), .MEM_LE(1)) dut1 (
    .clk(clk), .nreset(nreset), .start_hash(start1), .message_addr(maddr1),
    .message_size(msize1), .port_A_clk(pclk1), .port_A_addr(paddr1), .port_A_we(pwe1),
    .port_A_data_in(pdin1), .port_A_data_out(pdout1), .word_data(wd1), .word_valid(wv1),
    .word_ready(wr1), .word_idx(wi1), .word_last(wl1), .busy(busy1), .done(done1));

  always @(posedge clk) pdout0 <= mem[paddr0[7:0]];
  always @(posedge clk) begin
    s1     <= mem[paddr1[7:0]];
    pdout1 <= s1;
  end

  int tests = 0;
  int fails = 0;
  logic [36:0] exp0[$], exp1[$];
  logic [31:0] got0[$], got1[$];
  int dcnt0 = 0, dcnt1 = 0;
  logic pv0 = 0, pv1 = 0, pr0 = 0, pr1 = 0;
  logic [31:0] pd0 = 0, pd1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] msg_byte(input int base, input int k, input bit le);
    logic [31:0] w;
    w = mem[(base + k / 4) & 255];
    return le ? w[8*(k%4) +: 8] : w[31-8*(k%4) -: 8];
  endfunction

  // Byte-oriented reference: message bytes, 0x80, zero fill, 64-bit bit length
  task automatic expect_msg(input int sel, input int size, input int base);
    int nw, nb, p;
    logic [63:0] bl;
    logic [31:0] wd;
    logic [7:0]  b;
    nw = 16 * ((size + 8) / 64 + 1);
    nb = nw * 4;
    bl = 64'(size) * 64'd8;
    for (int i = 0; i < nw; i++) begin
      wd = 32'h0;
      for (int j = 0; j < 4; j++) begin
        p = 4 * i + j;
        if (p < size)         b = msg_byte(base, p, sel == 1);
        else if (p == size)   b = 8'h80;
        else if (p >= nb - 8) b = bl[63 - 8*(p - (nb - 8)) -: 8];
        else                  b = 8'h00;
        wd = {wd[23:0], b};
      end
      if (sel == 0) exp0.push_back({wd, 4'(i % 16), 1'(i == nw - 1)});
      else          exp1.push_back({wd, 4'(i % 16), 1'(i == nw - 1)});
    end
  endtask

  always @(negedge clk) begin
    logic [36:0] e;
    if (nreset) begin
      if (pv0 && !pr0) begin
        chk("hold_valid0", 32'(wv0), 32'd1);
        chk("hold_data0", wd0, pd0);
      end
      if (wv0 && wr0) begin
        if (exp0.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_word0: got %h expected no word", wd0);
        end else begin
          e = exp0.pop_front();
          chk("data0", wd0, e[36:5]);
          chk("idx0", 32'(wi0), 32'(e[4:1]));
          chk("last0", 32'(wl0), 32'(e[0]));
        end
        got0.push_back(wd0);
      end
      if (done0) dcnt0 <= dcnt0 + 1;
      if (pv1 && !pr1) begin
        chk("hold_valid1", 32'(wv1), 32'd1);
        chk("hold_data1", wd1, pd1);
      end
      if (wv1 && wr1) begin
        if (exp1.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_word1: got %h expected no word", wd1);
        end else begin
          e = exp1.pop_front();
          chk("data1", wd1, e[36:5]);
          chk("idx1", 32'(wi1), 32'(e[4:1]));
          chk("last1", 32'(wl1), 32'(e[0]));
        end
        got1.push_back(wd1);
      end
      if (done1) dcnt1 <= dcnt1 + 1;
    end
    pv0 <= nreset && wv0; pr0 <= wr0; pd0 <= wd0;
    pv1 <= nreset && wv1; pr1 <= wr1; pd1 <= wd1;
  end

  task automatic run(input int sel, input int size, input int base, input int hold);
    int nw, d, c, dn, gs, qs;
    logic bz;
    nw = 16 * ((size + 8) / 64 + 1);
    if (sel == 0) got0.delete(); else got1.delete();
    expect_msg(sel, size, base);
    d = (sel == 0) ? dcnt0 : dcnt1;
    @(posedge clk); #1;
    if (sel == 0) begin
      maddr0 = 16'(base); msize0 = 32'(size); start0 = 1'b1;
      if (hold > 0) wr0 = 1'b0;
    end else begin
      maddr1 = 16'(base); msize1 = 32'(size); start1 = 1'b1;
      if (hold > 0) wr1 = 1'b0;
    end
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 32'((sel == 0) ? busy0 : busy1), 32'd1);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1; wr0 = 1'b1; wr1 = 1'b1;
    end
    c = 0;
    dn = d;
    while (dn == d && c < 5000) begin
      @(posedge clk);
      c++;
      dn = (sel == 0) ? dcnt0 : dcnt1;
    end
    chk("done_seen", 32'(dn != d), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    dn = (sel == 0) ? dcnt0 : dcnt1;
    gs = (sel == 0) ? got0.size() : got1.size();
    qs = (sel == 0) ? exp0.size() : exp1.size();
    bz = (sel == 0) ? busy0 : busy1;
    chk("done_single", 32'(dn - d), 32'd1);
    chk("word_count", 32'(gs), 32'(nw));
    chk("leftover", 32'(qs), 32'd0);
    chk("busy_idle", 32'(bz), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    for (int i = 0; i < 256; i++) mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
    mem[8'h10] = 32'h6162_6300;
    for (int i = 0; i < 14; i++)
      mem[8'h20 + i] = {8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)};
    mem[8'h60] = 32'h6463_6261;
    mem[8'h61] = 32'h6867_6665;

    nreset = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    maddr0 = '0; maddr1 = '0; msize0 = '0; msize1 = '0;
    wr0 = 1'b1; wr1 = 1'b1;
    #12;
    chk("rst_valid0", 32'(wv0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_addr0", 32'(paddr0), 32'd0);
    chk("rst_data0", wd0, 32'd0);
    chk("rst_we0", 32'(pwe0), 32'd0);
    chk("rst_valid1", 32'(wv1), 32'd0);
    @(posedge clk); #1;
    nreset = 1'b1;

    run(0, 0, 8'h30, 0);
    chk("s0_w0", got0[0], 32'h8000_0000);
    chk("s0_w15", got0[15], 32'h0);

    run(0, 3, 8'h10, 0);
    chk("s3_w0", got0[0], 32'h6162_6380);
    chk("s3_w1", got0[1], 32'h0);
    chk("s3_w15", got0[15], 32'h0000_0018);

    run(0, 55, 8'h20, 0);
    chk("s55_w12", got0[12], 32'h3132_3334);
    chk("s55_w13", got0[13], 32'h3536_3780);
    chk("s55_w14", got0[14], 32'h0);
    chk("s55_w15", got0[15], 32'h0000_01B8);

    run(0, 56, 8'h20, 0);
    chk("s56_w13", got0[13], 32'h3536_3738);
    chk("s56_w14", got0[14], 32'h8000_0000);
    chk("s56_w15", got0[15], 32'h0);
    chk("s56_w30", got0[30], 32'h0);
    chk("s56_w31", got0[31], 32'h0000_01C0);

    run(1, 8, 8'h60, 10);
    chk("le_w0", got1[0], 32'h6162_6364);
    chk("le_w1", got1[1], 32'h6566_6768);
    chk("le_w2", got1[2], 32'h8000_0000);
    chk("le_w15", got1[15], 32'h0000_0040);

    // Abort a long message mid-stream, then a clean short one
    expect_msg(0, 200, 8'h40);
    d = dcnt0;
    @(posedge clk); #1;
    maddr0 = 16'h40; msize0 = 32'd200; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    nreset = 1'b0;
    exp0.delete();
    @(negedge clk);
    chk("abort_valid", 32'(wv0), 32'd0);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    @(posedge clk); #1;
    nreset = 1'b1;
    repeat (3) @(posedge clk);
    chk("abort_no_done", 32'(dcnt0 - d), 32'd0);

    run(0, 3, 8'h10, 0);
    chk("re_w0", got0[0], 32'h6162_6380);
    chk("re_w15", got0[15], 32'h0000_0018);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
